snowflake_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port iCE40UP EBR memory between the Kronos system bus (master 0) and a second bus master (master 1, e.g. a boot loader or debug port). It sits between those masters and the memory macro. It serialises accesses, registers the granted request onto the memory port, and returns read data with a one-cycle ack. Arbitration is round-robin by default, with an optional fixed-priority mode.

---
 rtl/snowflake_pkg.sv | 22 ++
 rtl/snowflake_rr_arb2.sv | 24 ++
 rtl/snowflake_mem_arbiter.sv | 109 ++++++++++
 tb/tb_snowflake_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snowflake_pkg.sv
// Shared types and constants for the snowflake memory arbiter slice.
package snowflake_pkg;

  localparam int MEM_WIDTH  = 32;
  localparam int MASK_WIDTH = MEM_WIDTH / 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_MEM, ARB_ACK} arb_state_e;

  typedef struct packed {
    logic [MEM_WIDTH-1:0]  addr;
    logic [MEM_WIDTH-1:0]  wr_data;
    logic [MASK_WIDTH-1:0] wr_mask;
    logic                  wr_en;
  } mem_req_t;

  // A read must never present byte enables to the memory macro.
  function automatic logic [MASK_WIDTH-1:0] masked_wr(input logic wr_en,
                                                      input logic [MASK_WIDTH-1:0] mask);
    return wr_en ? mask : '0;
  endfunction

endpackage

// File: rtl/snowflake_rr_arb2.sv
// Combinational two-way grant decision: round-robin on ties, or master 1 first
// when fixed priority is selected. Excluded requesters are treated as idle.
module snowflake_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       m1_priority,
  input  logic [1:0] exclude,
  output logic       valid,
  output logic       grant
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req & ~exclude;
    valid    = |eligible;
    if (eligible == 2'b11) begin
      grant = m1_priority ? 1'b1 : ~last;
    end else begin
      grant = eligible[1];
    end
  end

endmodule

// File: rtl/snowflake_mem_arbiter.sv
// Two-master arbiter in front of a single-port EBR: serialises accesses,
// registers the granted request onto the memory port, acks one cycle after the access.
module snowflake_mem_arbiter
  import snowflake_pkg::*;
#(
  parameter bit M1_PRIORITY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstz,
  input  logic [MEM_WIDTH-1:0]  m0_addr,
  input  logic [MEM_WIDTH-1:0]  m0_wr_data,
  input  logic [MASK_WIDTH-1:0] m0_wr_mask,
  input  logic                  m0_wr_en,
  input  logic                  m0_req,
  output logic                  m0_ack,
  output logic [MEM_WIDTH-1:0]  m0_rd_data,
  input  logic [MEM_WIDTH-1:0]  m1_addr,
  input  logic [MEM_WIDTH-1:0]  m1_wr_data,
  input  logic [MASK_WIDTH-1:0] m1_wr_mask,
  input  logic                  m1_wr_en,
  input  logic                  m1_req,
  output logic                  m1_ack,
  output logic [MEM_WIDTH-1:0]  m1_rd_data,
  output logic [MEM_WIDTH-1:0]  mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wr_data,
  output logic [MASK_WIDTH-1:0] mem_wr_mask,
  output logic                  mem_wr_en,
  output logic                  mem_en,
  input  logic [MEM_WIDTH-1:0]  mem_rd_data
);

  arb_state_e           state_reg;
  logic                 grant_reg;
  logic                 last_reg;
  logic                 mem_en_reg;
  mem_req_t             mem_reg;
  mem_req_t             fields [2];
  mem_req_t             granted;
  logic [1:0]           req_vec;
  logic [1:0]           exclude;
  logic [1:0]           ack_vec;
  logic [MEM_WIDTH-1:0] rd_vec [2];
  logic                 pick_valid;
  logic                 pick_grant;

  assign fields[0] = '{addr: m0_addr, wr_data: m0_wr_data, wr_mask: m0_wr_mask, wr_en: m0_wr_en};
  assign fields[1] = '{addr: m1_addr, wr_data: m1_wr_data, wr_mask: m1_wr_mask, wr_en: m1_wr_en};
  assign req_vec   = {m1_req, m0_req};

  // The master being acked still holds req this cycle; keep it out of the decision.
  assign exclude = (state_reg == ARB_ACK) ? (grant_reg ? 2'b10 : 2'b01) : 2'b00;

  snowflake_rr_arb2 u_rr_arb2 (
    .req         (req_vec),
    .last        (last_reg),
    .m1_priority (M1_PRIORITY),
    .exclude     (exclude),
    .valid       (pick_valid),
    .grant       (pick_grant)
  );

  always_comb begin
    granted         = fields[pick_grant];
    granted.wr_mask = masked_wr(granted.wr_en, granted.wr_mask);
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_reg  <= ARB_IDLE;
      grant_reg  <= 1'b0;
      last_reg   <= 1'b1;
      mem_en_reg <= 1'b0;
      mem_reg    <= '0;
    end else begin
      mem_en_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE, ARB_ACK: begin
          if (pick_valid) begin
            state_reg  <= ARB_MEM;
            grant_reg  <= pick_grant;
            last_reg   <= pick_grant;
            mem_reg    <= granted;
            mem_en_reg <= 1'b1;
          end else begin
            state_reg <= ARB_IDLE;
          end
        end
        ARB_MEM: state_reg <= ARB_ACK;
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ack_vec[gi] = (state_reg == ARB_ACK) && (grant_reg == 1'(gi));
    assign rd_vec[gi]  = ack_vec[gi] ? mem_rd_data : '0;
  end

  assign m0_ack      = ack_vec[0];
  assign m1_ack      = ack_vec[1];
  assign m0_rd_data  = rd_vec[0];
  assign m1_rd_data  = rd_vec[1];
  assign mem_addr    = mem_reg.addr;
  assign mem_wr_data = mem_reg.wr_data;
  assign mem_wr_mask = mem_reg.wr_mask;
  assign mem_wr_en   = mem_reg.wr_en;
  assign mem_en      = mem_en_reg;

endmodule

// File: tb/tb_snowflake_mem_arbiter.sv
// Bench for snowflake_mem_arbiter: round-robin and fixed-priority instances driven side by side,
// checked every cycle against a slot-schedule model of the arbitration rules.
module tb_snowflake_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstz;
  logic        mem_load;
  logic [31:0] addr        [2][2];
  logic [31:0] wr_data     [2][2];
  logic [3:0]  wr_mask     [2][2];
  logic        wr_en       [2][2];
  logic        req         [2][2];
  logic        ack         [2][2];
  logic [31:0] rd_data     [2][2];
  logic [31:0] mem_addr    [2];
  logic [31:0] mem_wr_data [2];
  logic [31:0] mem_rd_data [2];
  logic [3:0]  mem_wr_mask [2];
  logic        mem_wr_en   [2];
  logic        mem_en      [2];
  logic [31:0] phys        [2][16];

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0111);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    snowflake_mem_arbiter #(.M1_PRIORITY(k == 1)) u_dut (
      .clk         (clk),
      .rstz        (rstz),
      .m0_addr     (addr[k][0]),
      .m0_wr_data  (wr_data[k][0]),
      .m0_wr_mask  (wr_mask[k][0]),
      .m0_wr_en    (wr_en[k][0]),
      .m0_req      (req[k][0]),
      .m0_ack      (ack[k][0]),
      .m0_rd_data  (rd_data[k][0]),
      .m1_addr     (addr[k][1]),
      .m1_wr_data  (wr_data[k][1]),
      .m1_wr_mask  (wr_mask[k][1]),
      .m1_wr_en    (wr_en[k][1]),
      .m1_req      (req[k][1]),
      .m1_ack      (ack[k][1]),
      .m1_rd_data  (rd_data[k][1]),
      .mem_addr    (mem_addr[k]),
      .mem_wr_data (mem_wr_data[k]),
      .mem_wr_mask (mem_wr_mask[k]),
      .mem_wr_en   (mem_wr_en[k]),
      .mem_en      (mem_en[k]),
      .mem_rd_data (mem_rd_data[k])
    );

    // Memory macro stand-in: registered read, byte-masked write.
    always @(posedge clk) begin
      if (mem_load) begin
        for (int i = 0; i < 16; i++) phys[k][i] <= init_word(i);
      end else if (mem_en[k]) begin
        for (int b = 0; b < 4; b++)
          if (mem_wr_en[k] && mem_wr_mask[k][b])
            phys[k][mem_addr[k][5:2]][8*b +: 8] <= mem_wr_data[k][8*b +: 8];
        mem_rd_data[k] <= phys[k][mem_addr[k][5:2]];
      end
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: each access occupies a slot starting at a decision cycle,
  // strobes memory one cycle later and acks two cycles later.
  int          dec_c [2];
  int          en_c  [2];
  int          ack_c [2];
  int          who   [2];
  int          excl  [2];
  logic        last_m [2];
  logic [31:0] f_addr [2];
  logic [31:0] f_data [2];
  logic [3:0]  f_mask [2];
  logic        f_we   [2];
  logic [31:0] ref_mem [2][16];
  logic        exp_ack [2][2];

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s inst%0d cyc%0d: got %h want %h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_eval(input int k);
    logic e0, e1, w;
    int   idx;
    if (rstz !== 1'b1) begin
      check("rst_ack0", k, 32'(ack[k][0]), 0);
      check("rst_ack1", k, 32'(ack[k][1]), 0);
      check("rst_rd0", k, rd_data[k][0], 0);
      check("rst_rd1", k, rd_data[k][1], 0);
      check("rst_en", k, 32'(mem_en[k]), 0);
      check("rst_addr", k, mem_addr[k], 0);
      check("rst_wdata", k, mem_wr_data[k], 0);
      check("rst_mask", k, 32'(mem_wr_mask[k]), 0);
      check("rst_we", k, 32'(mem_wr_en[k]), 0);
      dec_c[k] = cyc + 1;
      en_c[k]  = -1;
      ack_c[k] = -1;
      excl[k]  = -1;
      last_m[k] = 1'b1;
      exp_ack[k][0] = 1'b0;
      exp_ack[k][1] = 1'b0;
      return;
    end
    idx = int'(f_addr[k][5:2]);
    for (int i = 0; i < 2; i++) begin
      exp_ack[k][i] = (ack_c[k] == cyc) && (who[k] == i);
      check($sformatf("ack%0d", i), k, 32'(ack[k][i]), 32'(exp_ack[k][i]));
      if (!exp_ack[k][i]) check($sformatf("rd%0d_idle", i), k, rd_data[k][i], 0);
      else if (!f_we[k])  check($sformatf("rd%0d_data", i), k, rd_data[k][i], ref_mem[k][idx]);
    end
    if (ack_c[k] == cyc && f_we[k])
      for (int b = 0; b < 4; b++)
        if (f_mask[k][b]) ref_mem[k][idx][8*b +: 8] = f_data[k][8*b +: 8];
    check("mem_en", k, 32'(mem_en[k]), 32'(en_c[k] == cyc));
    if (en_c[k] == cyc) begin
      check("mem_addr", k, mem_addr[k], f_addr[k]);
      check("mem_wdata", k, mem_wr_data[k], f_data[k]);
      check("mem_we", k, 32'(mem_wr_en[k]), 32'(f_we[k]));
      check("mem_mask", k, 32'(mem_wr_mask[k]), f_we[k] ? 32'(f_mask[k]) : 0);
    end
    if (cyc == dec_c[k]) begin
      e0 = req[k][0] && (excl[k] != 0);
      e1 = req[k][1] && (excl[k] != 1);
      if (!e0 && !e1) begin
        dec_c[k] = cyc + 1;
        excl[k]  = -1;
      end else begin
        if (e0 && e1) w = (k == 1) ? 1'b1 : !last_m[k];
        else          w = e1;
        who[k]    = int'(w);
        last_m[k] = w;
        f_addr[k] = addr[k][w];
        f_data[k] = wr_data[k][w];
        f_mask[k] = wr_mask[k][w];
        f_we[k]   = wr_en[k][w];
        en_c[k]   = cyc + 1;
        ack_c[k]  = cyc + 2;
        dec_c[k]  = cyc + 2;
        excl[k]   = int'(w);
      end
    end
  endtask

  task automatic new_fields(input int k, input int i);
    logic [31:0] r;
    r = $urandom();
    addr[k][i]    = r & 32'hFFFF_FFFC;
    wr_data[k][i] = $urandom();
    r = $urandom();
    wr_mask[k][i] = r[3:0];
    wr_en[k][i]   = r[4];
  endtask

  task automatic set_req(input int k, input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic we);
    addr[k][i] = a; wr_data[k][i] = d; wr_mask[k][i] = m; wr_en[k][i] = we; req[k][i] = 1'b1;
  endtask

  // One clock: check/model at the falling edge, then masters react just after the rising edge.
  task automatic tick(input bit rnd);
    @(negedge clk);
    model_eval(0);
    model_eval(1);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++) begin
        if (exp_ack[k][i]) begin
          if (rnd && $urandom_range(1, 0) == 1) new_fields(k, i);
          else req[k][i] = 1'b0;
        end else if (rnd && !req[k][i] && $urandom_range(9, 0) < 4) begin
          new_fields(k, i);
          req[k][i] = 1'b1;
        end
      end
  endtask

  initial begin
    rstz = 1'b0;
    mem_load = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        req[k][i] = 1'b0; addr[k][i] = '0; wr_data[k][i] = '0; wr_mask[k][i] = '0; wr_en[k][i] = 1'b0;
      end
      for (int j = 0; j < 16; j++) ref_mem[k][j] = init_word(j);
      f_addr[k] = '0; f_data[k] = '0; f_mask[k] = '0; f_we[k] = 1'b0;
      dec_c[k] = 0; en_c[k] = -1; ack_c[k] = -1; who[k] = 0; excl[k] = -1; last_m[k] = 1'b1;
      exp_ack[k][0] = 1'b0; exp_ack[k][1] = 1'b0;
    end
    repeat (3) tick(0);
    rstz = 1'b1;
    mem_load = 1'b0;

    // Master 0 reads 0x10 alone.
    for (int k = 0; k < 2; k++) set_req(k, 0, 32'h10, 32'h0BAD_F00D, 4'hF, 1'b0);
    tick(0);
    check("t1_en", 0, 32'(mem_en[0]), 1);
    check("t1_addr", 0, mem_addr[0], 32'h10);
    check("t1_mask", 0, 32'(mem_wr_mask[0]), 0);
    tick(0);
    check("t1_ack0", 0, 32'(ack[0][0]), 1);
    check("t1_rd0", 0, rd_data[0][0], 32'hDEADBEEF);
    check("t1_ack1", 0, 32'(ack[0][1]), 0);
    tick(0);

    // Master 1 writes 0xA5A5A5A5 with mask 0x3 to 0x20.
    for (int k = 0; k < 2; k++) set_req(k, 1, 32'h20, 32'hA5A5_A5A5, 4'h3, 1'b1);
    tick(0);
    check("t2_we", 0, 32'(mem_wr_en[0]), 1);
    check("t2_mask", 0, 32'(mem_wr_mask[0]), 32'h3);
    check("t2_wdata", 0, mem_wr_data[0], 32'hA5A5_A5A5);
    tick(0);
    check("t2_ack1", 0, 32'(ack[0][1]), 1);
    tick(0);

    // Simultaneous tie with master 1 last served: RR picks 0, priority picks 1.
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 32'h30, 32'h0, 4'h0, 1'b0);
      set_req(k, 1, 32'h34, 32'h0, 4'h0, 1'b0);
    end
    tick(0);
    tick(0);
    check("t3_rr_ack0", 0, 32'(ack[0][0]), 1);
    check("t3_pr_ack1", 1, 32'(ack[1][1]), 1);
    tick(0);
    check("t3_b2b_en", 0, 32'(mem_en[0]), 1);
    tick(0);
    check("t3_rr_ack1", 0, 32'(ack[0][1]), 1);
    check("t3_pr_ack0", 1, 32'(ack[1][0]), 1);
    tick(0);

    // Reset pulsed during the memory cycle drops the access.
    for (int k = 0; k < 2; k++) set_req(k, 0, 32'h08, 32'h0, 4'h0, 1'b0);
    tick(0);
    rstz = 1'b0;
    #1;
    check("t5_en_rst", 0, 32'(mem_en[0]), 0);
    check("t5_addr_rst", 0, mem_addr[0], 0);
    tick(0);
    rstz = 1'b1;
    tick(0);
    tick(0);
    check("t5_ack0", 0, 32'(ack[0][0]), 1);
    tick(0);

    // Master 0 keeps requesting through its ack: next access acks 3 cycles later.
    for (int k = 0; k < 2; k++) set_req(k, 0, 32'h14, 32'h0, 4'h0, 1'b0);
    tick(0);
    tick(0);
    check("t6_ack_a", 0, 32'(ack[0][0]), 1);
    tick(0);
    for (int k = 0; k < 2; k++) set_req(k, 0, 32'h18, 32'h5566_7788, 4'hF, 1'b1);
    check("t6_gap1", 0, 32'(ack[0][0]), 0);
    tick(0);
    check("t6_gap2", 0, 32'(ack[0][0]), 0);
    check("t6_addr", 0, mem_addr[0], 32'h18);
    tick(0);
    check("t6_ack_b", 0, 32'(ack[0][0]), 1);
    tick(0);

    // Tie with master 0 last served: round-robin now favours master 1.
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, 32'h18, 32'h0, 4'h0, 1'b0);
      set_req(k, 1, 32'h20, 32'h0, 4'h0, 1'b0);
    end
    tick(0);
    tick(0);
    check("t7_rr_ack1", 0, 32'(ack[0][1]), 1);
    check("t7_rr_ack0", 0, 32'(ack[0][0]), 0);
    tick(0);
    tick(0);
    check("t7_rr_ack0b", 0, 32'(ack[0][0]), 1);
    tick(0);

    repeat (3000) tick(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
